// File: rtl/led_mode_controller_if.sv
// rtl/led_mode_controller_if.sv - switch/button inputs and LED/mode outputs of the LED mode controller
interface led_mode_controller_if;
  logic [7:0] switch;
  logic       btn;
  logic [7:0] led;
  logic [1:0] mode;

  modport master (output switch, output btn, input led, input mode);
  modport slave  (input switch, input btn, output led, output mode);
endinterface

// File: rtl/led_mode_controller.sv
// rtl/led_mode_controller.sv - debounced switch-to-LED path with four button-selected display modes
module led_mode_controller #(
  parameter int DEB_CYCLES = 500000,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  led_mode_controller_if.slave        io
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int PW = $clog2(TICK_DIV);
  // The candidate load already costs one cycle, so acceptance happens on the
  // increment that would bring the count to DEB_CYCLES-1.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 2);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  logic [7:0]    sw_meta_q, sw_sync_q, sw_cand_q, sw_db_q;
  logic [DW-1:0] sw_cnt_q;
  logic          btn_meta_q, btn_sync_q, btn_cand_q, btn_db_q, btn_prev_q;
  logic [DW-1:0] btn_cnt_q;

  mode_e         state_q, state_d;
  logic [PW-1:0] presc_q;
  logic          phase_q;
  logic [7:0]    chase_q;
  logic [7:0]    count_q;
  logic [7:0]    led_q, led_d;

  logic          press;
  logic          tick;

  // Two-flop synchronisers for the asynchronous switch bank and button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
    end else begin
      sw_meta_q  <= io.switch;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= io.btn;
      btn_sync_q <= btn_meta_q;
    end
  end

  // Switch debounce: the whole vector must hold still before it is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_cand_q <= '0;
      sw_db_q   <= '0;
      sw_cnt_q  <= '0;
    end else if (sw_sync_q != sw_cand_q) begin
      sw_cand_q <= sw_sync_q;
      sw_cnt_q  <= '0;
    end else if (sw_cand_q != sw_db_q) begin
      if (sw_cnt_q == DEB_LAST) begin
        sw_db_q  <= sw_cand_q;
        sw_cnt_q <= '0;
      end else begin
        sw_cnt_q <= sw_cnt_q + 1'b1;
      end
    end else begin
      sw_cnt_q <= '0;
    end
  end

  // Button debounce, plus the delayed copy used for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_cand_q <= 1'b0;
      btn_db_q   <= 1'b0;
      btn_cnt_q  <= '0;
      btn_prev_q <= 1'b0;
    end else begin
      btn_prev_q <= btn_db_q;
      if (btn_sync_q != btn_cand_q) begin
        btn_cand_q <= btn_sync_q;
        btn_cnt_q  <= '0;
      end else if (btn_cand_q != btn_db_q) begin
        if (btn_cnt_q == DEB_LAST) begin
          btn_db_q  <= btn_cand_q;
          btn_cnt_q <= '0;
        end else begin
          btn_cnt_q <= btn_cnt_q + 1'b1;
        end
      end else begin
        btn_cnt_q <= '0;
      end
    end
  end

  assign press   = btn_db_q & ~btn_prev_q;
  assign tick    = (presc_q == TICK_LAST);
  assign state_d = mode_e'(state_q + 2'd1);

  // LED value for the current mode; registered on the next edge
  always_comb begin
    led_d = 8'h00;
    case (state_q)
      MODE_PASS:  led_d = sw_db_q;
      MODE_BLINK: led_d = phase_q ? sw_db_q : 8'h00;
      MODE_CHASE: led_d = chase_q;
      MODE_COUNT: led_d = count_q;
      default:    led_d = 8'h00;
    endcase
  end

  // Mode FSM with prescaler and per-mode animation state; a press overrides a coincident tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MODE_PASS;
      presc_q <= '0;
      phase_q <= 1'b1;
      chase_q <= 8'h01;
      count_q <= 8'h00;
      led_q   <= 8'h00;
    end else begin
      led_q <= led_d;
      if (press) begin
        state_q <= state_d;
        presc_q <= '0;
        phase_q <= 1'b1;
        chase_q <= 8'h01;
        count_q <= 8'h00;
      end else begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          case (state_q)
            MODE_BLINK: phase_q <= ~phase_q;
            MODE_CHASE: chase_q <= sw_db_q[7] ? {chase_q[0], chase_q[7:1]}
                                              : {chase_q[6:0], chase_q[7]};
            MODE_COUNT: count_q <= count_q + 1'b1;
            default:    ;
          endcase
        end
      end
    end
  end

  assign io.led  = led_q;
  assign io.mode = state_q;

endmodule

// File: tb/tb_led_mode_controller.sv
// tb/tb_led_mode_controller.sv - randomized bench for led_mode_controller against an elapsed-time reference model
module tb_led_mode_controller;

  localparam int DEB = 4;
  localparam int TD  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_mode_controller_if bus();

  led_mode_controller #(.DEB_CYCLES(DEB), .TICK_DIV(TD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: inputs delayed two cycles, accepted after DEB equal samples,
  // animation derived from cycles elapsed since the last mode entry.
  logic [7:0] sw_pipe[$];
  logic       btn_pipe[$];
  logic [7:0] m_sw_last, m_sw_db;
  int         m_sw_run;
  logic       m_btn_last, m_btn_db;
  int         m_btn_run;
  logic       m_press;
  int         m_mode;
  int         m_n;
  logic [7:0] m_chase;
  logic [7:0] m_led;

  task automatic model_reset();
    sw_pipe    = '{8'h00, 8'h00};
    btn_pipe   = '{1'b0, 1'b0};
    m_sw_last  = 8'h00;
    m_sw_db    = 8'h00;
    m_sw_run   = 0;
    m_btn_last = 1'b0;
    m_btn_db   = 1'b0;
    m_btn_run  = 0;
    m_press    = 1'b0;
    m_mode     = 0;
    m_n        = 0;
    m_chase    = 8'h01;
    m_led      = 8'h00;
  endtask

  function automatic logic [7:0] m_display();
    int ticks;
    ticks = m_n / TD;
    case (m_mode)
      0:       return m_sw_db;
      1:       return (ticks % 2 == 0) ? m_sw_db : 8'h00;
      2:       return m_chase;
      default: return 8'(ticks % 256);
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] sv;
    logic       bv;
    logic [7:0] disp;
    logic       tick;
    logic       old_db;
    disp = m_display();
    tick = (m_n % TD) == TD - 1;
    if (m_press) begin
      m_mode  = (m_mode + 1) % 4;
      m_n     = 0;
      m_chase = 8'h01;
    end else begin
      if (tick && m_mode == 2)
        m_chase = m_sw_db[7] ? {m_chase[0], m_chase[7:1]} : {m_chase[6:0], m_chase[7]};
      m_n++;
    end
    sv = sw_pipe.pop_front();
    sw_pipe.push_back(bus.switch);
    if (sv == m_sw_last) m_sw_run++;
    else begin m_sw_last = sv; m_sw_run = 1; end
    if (m_sw_run == DEB && sv != m_sw_db) m_sw_db = sv;
    bv = btn_pipe.pop_front();
    btn_pipe.push_back(bus.btn);
    if (bv == m_btn_last) m_btn_run++;
    else begin m_btn_last = bv; m_btn_run = 1; end
    old_db = m_btn_db;
    if (m_btn_run == DEB && bv != m_btn_db) m_btn_db = bv;
    m_press = m_btn_db && !old_db;
    m_led   = disp;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    chk("led", {24'h0, bus.led}, {24'h0, m_led});
    chk("mode", {30'h0, bus.mode}, m_mode);
  endtask

  task automatic press_btn(input int hold);
    bus.btn = 1'b1;
    repeat (hold) cyc();
    bus.btn = 1'b0;
  endtask

  initial begin
    bus.switch = 8'h00;
    bus.btn    = 1'b0;
    rst_n      = 1'b0;
    model_reset();
    repeat (3) cyc();
    chk("reset_led", {24'h0, bus.led}, 32'h0);
    chk("reset_mode", {30'h0, bus.mode}, 32'h0);
    rst_n = 1'b1;

    bus.switch = 8'hA5;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      if (i == 6) chk("lat_before", {24'h0, bus.led}, 32'h00);
      if (i == 7) chk("lat_after", {24'h0, bus.led}, 32'hA5);
    end

    bus.switch = 8'h00;
    repeat (10) cyc();
    bus.switch = 8'hFF;
    repeat (3) cyc();
    bus.switch = 8'h00;
    repeat (12) begin
      cyc();
      chk("glitch", {24'h0, bus.led}, 32'h00);
    end

    bus.switch = 8'h3C;
    repeat (10) cyc();
    press_btn(10);
    chk("mode_blink", {30'h0, bus.mode}, 32'd1);
    repeat (40) cyc();

    press_btn(10);
    chk("mode_chase", {30'h0, bus.mode}, 32'd2);
    repeat (40) cyc();
    bus.switch = 8'hBC;
    repeat (60) cyc();

    press_btn(10);
    chk("mode_count", {30'h0, bus.mode}, 32'd3);
    repeat (40) cyc();
    bus.switch = 8'h5A;
    repeat (256 * TD) cyc();
    press_btn(10);
    chk("mode_pass", {30'h0, bus.mode}, 32'd0);
    repeat (10) cyc();
    chk("pass_sw", {24'h0, bus.led}, 32'h5A);

    // press pulse lands on the tick edge for three consecutive mode changes
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < TD && (m_n % TD) != 1; w++) cyc();
      press_btn(10);
      repeat (20) cyc();
    end
    chk("coincide_mode", {30'h0, bus.mode}, 32'd3);

    repeat (30) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", {24'h0, bus.led}, 32'h00);
    chk("async_rst_mode", {30'h0, bus.mode}, 32'h0);
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (12) cyc();

    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.btn = 1'b1;
        repeat ($urandom_range(1, 12)) cyc();
        bus.btn = 1'b0;
      end else begin
        bus.switch = 8'($urandom);
      end
      repeat ($urandom_range(1, 12)) cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
